// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the bit-serial neuron datapath.
// Q5.10 sign-magnitude operands and two's-complement conversion helpers.
package nn_fixed_pkg;

  localparam int INT_W       = 5;
  localparam int FRAC_W      = 10;
  localparam int DATA_W      = 1 + INT_W + FRAC_W;
  localparam int MULT_CYCLES = 16;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPTURE,
    DONE
  } seq_state_t;

  // Negative zero maps to plain zero.
  function automatic logic signed [DATA_W:0] sm_to_tc(input logic [DATA_W-1:0] sm);
    logic signed [DATA_W:0] mag;
    mag = {2'b00, sm[DATA_W-2:0]};
    return sm[DATA_W-1] ? -mag : mag;
  endfunction

  // Caller guarantees |tc| <= SAT_MAX, so the magnitude fits DATA_W-1 bits.
  function automatic logic [DATA_W-1:0] tc_to_sm(input logic signed [DATA_W+1:0] tc);
    logic [DATA_W-2:0] mag;
    mag = tc[DATA_W+1] ? (DATA_W-1)'(-tc) : (DATA_W-1)'(tc);
    return {tc[DATA_W+1], mag};
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Pair stream, Mult drive/return and dot-product stream of the multiplier sequencer.
interface mult_seq_ctrl_if;
  import nn_fixed_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_neuron;
  logic [DATA_W-1:0] in_weight;
  logic              in_last;

  logic              mult_reset_n;
  logic              mult_enable;
  logic [DATA_W-1:0] mult_input_neuron;
  logic              mult_weight_bit;
  logic [DATA_W-1:0] mult_out;

  logic              acc_valid;
  logic              acc_ready;
  logic [DATA_W-1:0] acc_out;
  logic              sat_flag;
  logic              busy;

  modport slave (
    input  in_valid, in_neuron, in_weight, in_last, mult_out, acc_ready,
    output in_ready, mult_reset_n, mult_enable, mult_input_neuron, mult_weight_bit,
    output acc_valid, acc_out, sat_flag, busy
  );

  modport master (
    output in_valid, in_neuron, in_weight, in_last, mult_out, acc_ready,
    input  in_ready, mult_reset_n, mult_enable, mult_input_neuron, mult_weight_bit,
    input  acc_valid, acc_out, sat_flag, busy
  );

endinterface

// File: rtl/sm_sat_acc.sv
// Saturating signed accumulator: sign-magnitude addend in, sign-magnitude sum out.
// Clamps to +/-SAT_MAX and keeps a sticky saturation flag until cleared.
module sm_sat_acc
  import nn_fixed_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_sm,
  output logic [DATA_W-1:0] acc_sm,
  output logic              sat_flag,
  output logic              nonzero
);

  localparam logic signed [DATA_W+1:0] ACC_MAX = {2'b00, SAT_MAX};
  localparam logic signed [DATA_W+1:0] ACC_MIN = -ACC_MAX;

  logic signed [DATA_W+1:0] acc_q;
  logic signed [DATA_W+1:0] sum;
  logic signed [DATA_W+1:0] sum_clamped;
  logic signed [DATA_W:0]   add_tc;
  logic                     clamp;

  always_comb begin
    add_tc      = sm_to_tc(add_sm);
    sum         = acc_q + {add_tc[DATA_W], add_tc};
    sum_clamped = sum;
    clamp       = 1'b0;
    if (sum > ACC_MAX) begin
      sum_clamped = ACC_MAX;
      clamp       = 1'b1;
    end else if (sum < ACC_MIN) begin
      sum_clamped = ACC_MIN;
      clamp       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_q    <= '0;
      sat_flag <= 1'b0;
    end else if (add_en) begin
      acc_q <= sum_clamped;
      if (clamp) sat_flag <= 1'b1;
    end
  end

  assign acc_sm  = tc_to_sm(acc_q);
  assign nonzero = (acc_q != '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Serialises (neuron, weight) pairs LSB-first into one bit-serial Mult and accumulates a dot product.
// 18 cycles per pair (2 for zero pairs when MULT_SEQ_ZERO_SKIP_EN is defined); in_ready is the only upstream back-pressure.
module mult_seq_ctrl
  import nn_fixed_pkg::*;
(
  input logic            clk,
  input logic            reset,
  mult_seq_ctrl_if.slave bus
);

  localparam int K_W = $clog2(MULT_CYCLES);

  seq_state_t        state, state_nxt;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] neuron_q;
  logic [DATA_W-1:0] weight_q;
  logic              last_q;
  logic              accept;
  logic              acc_add;
  logic              acc_clr;
  logic              acc_nonzero;
  logic [DATA_W-1:0] add_sm;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  logic zero_pair;
  logic skip_q;

  assign zero_pair = (bus.in_neuron[DATA_W-2:0] == '0) || (bus.in_weight[DATA_W-2:0] == '0);

  always_ff @(posedge clk) begin
    if (reset) skip_q <= 1'b0;
    else if (accept) skip_q <= zero_pair;
  end

  // Mult never ran for a skipped pair, so its output is stale.
  assign add_sm = skip_q ? '0 : bus.mult_out;
`else
  localparam logic zero_pair = 1'b0;

  assign add_sm = bus.mult_out;
`endif

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      neuron_q <= '0;
      weight_q <= '0;
      last_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        neuron_q <= bus.in_neuron;
        weight_q <= bus.in_weight;
        last_q   <= bus.in_last;
        k        <= '0;
      end else if (state == RUN) begin
        k <= k + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt           = state;
    bus.in_ready        = 1'b0;
    bus.mult_enable     = 1'b0;
    bus.mult_weight_bit = 1'b0;
    bus.acc_valid       = 1'b0;
    acc_add             = 1'b0;
    acc_clr             = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = !reset;
        if (bus.in_valid && !reset) state_nxt = zero_pair ? CAPTURE : RUN;
      end
      RUN: begin
        bus.mult_enable     = 1'b1;
        bus.mult_weight_bit = weight_q[k];
        if (k == K_W'(MULT_CYCLES - 1)) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        acc_add   = 1'b1;
        state_nxt = last_q ? DONE : IDLE;
      end
      DONE: begin
        bus.acc_valid = 1'b1;
        if (bus.acc_ready) begin
          acc_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sm_sat_acc u_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr),
    .add_en   (acc_add),
    .add_sm   (add_sm),
    .acc_sm   (bus.acc_out),
    .sat_flag (bus.sat_flag),
    .nonzero  (acc_nonzero)
  );

  assign bus.mult_reset_n      = ~reset;
  assign bus.mult_input_neuron = neuron_q;
  assign bus.busy              = (state != IDLE) || acc_nonzero;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural bit-serial Q5.10 Mult attached.
module tb_mult_seq_ctrl;
  import nn_fixed_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_seq_ctrl_if bus ();

  mult_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural Mult: weight shifted in LSB-first, product truncated to Q5.10.
  logic [15:0] m_wsh;
  int          en_cnt = 0;
  logic [29:0] m_prod;
  logic [29:0] m_scaled;

  always @(posedge clk) begin
    if (!bus.mult_reset_n) m_wsh <= '0;
    else if (bus.mult_enable) m_wsh <= {bus.mult_weight_bit, m_wsh[15:1]};
    if (bus.mult_enable) en_cnt <= en_cnt + 1;
  end

  assign m_prod   = 30'(bus.mult_input_neuron[14:0]) * 30'(m_wsh[14:0]);
  assign m_scaled = m_prod >> 10;
  assign bus.mult_out = {bus.mult_input_neuron[15] ^ m_wsh[15],
                         (m_scaled > 30'd32767) ? 15'h7FFF : m_scaled[14:0]};

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send_pair(input logic [15:0] n, input logic [15:0] w, input logic last);
    int t = 0;
    bus.in_valid  = 1'b1;
    bus.in_neuron = n;
    bus.in_weight = w;
    bus.in_last   = last;
    while (bus.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      failures++;
      $display("FAIL send_pair_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Edge count with the accept edge counted as edge 1.
  task automatic wait_valid(input int start, output int edges);
    edges = start;
    while (bus.acc_valid !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic take_result();
    bus.acc_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in_neuron = 16'h0400;
    bus.in_weight = 16'h0400;
    bus.in_last   = 1'b1;
    bus.acc_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.mult_reset_n, bus.mult_enable, bus.mult_weight_bit,
         bus.acc_valid, bus.sat_flag, bus.busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=0000000", {bus.in_ready, bus.mult_reset_n,
               bus.mult_enable, bus.mult_weight_bit, bus.acc_valid, bus.sat_flag, bus.busy});
    end
    checks++;
    if (bus.acc_out !== 16'h0000 || bus.mult_input_neuron !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data acc_out=%h neuron=%h required=0000/0000", bus.acc_out, bus.mult_input_neuron);
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mult_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_idle in_ready=%b mult_reset_n=%b required=1/1", bus.in_ready, bus.mult_reset_n);
    end
  endtask

  task automatic test_single();
    int          base;
    int          e;
    logic [15:0] seq;
    base = en_cnt;
    seq  = '0;
    send_pair(16'h0600, 16'h0800, 1'b1);
    e = 1;
    checks++;
    if (bus.mult_input_neuron !== 16'h0600) begin
      failures++;
      $display("FAIL single_neuron got=%h required=0600", bus.mult_input_neuron);
    end
    for (int i = 0; i < 16; i++) begin
      seq[i] = bus.mult_enable & bus.mult_weight_bit;
      @(negedge clk);
      e++;
    end
    wait_valid(e, e);
    checks++;
    if (e !== 18) begin
      failures++;
      $display("FAIL single_latency edges=%0d required=18", e);
    end
    checks++;
    if (seq !== 16'h0800 || m_wsh !== 16'h0800) begin
      failures++;
      $display("FAIL single_bits seq=%h shifted=%h required=0800", seq, m_wsh);
    end
    checks++;
    if (en_cnt - base !== 16) begin
      failures++;
      $display("FAIL single_enables got=%0d required=16", en_cnt - base);
    end
    checks++;
    if (bus.acc_out !== 16'h0C00 || bus.sat_flag !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL single_result acc=%h sat=%b rdy=%b busy=%b required=0c00/0/0/1",
               bus.acc_out, bus.sat_flag, bus.in_ready, bus.busy);
    end
    take_result();
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.acc_out !== 16'h0000) begin
      failures++;
      $display("FAIL single_handshake valid=%b rdy=%b busy=%b acc=%h required=0/1/0/0000",
               bus.acc_valid, bus.in_ready, bus.busy, bus.acc_out);
    end
  endtask

  // acc_ready held high throughout: must be ignored until DONE.
  task automatic test_mixed_sign();
    int e;
    bus.acc_ready = 1'b1;
    send_pair(16'h0600, 16'h0800, 1'b0);
    send_pair(16'h8600, 16'h0400, 1'b1);
    wait_valid(1, e);
    checks++;
    if (bus.acc_out !== 16'h0600 || bus.sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL mixed_sign acc=%h sat=%b required=0600/0", bus.acc_out, bus.sat_flag);
    end
    @(negedge clk);
    bus.acc_ready = 1'b0;
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mixed_sign_drain valid=%b busy=%b required=0/0", bus.acc_valid, bus.busy);
    end
  endtask

  task automatic test_saturate();
    int e;
    send_pair(16'h7C00, 16'h0400, 1'b0);
    send_pair(16'h7C00, 16'h0400, 1'b1);
    wait_valid(1, e);
    checks++;
    if (bus.acc_out !== 16'h7FFF || bus.sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL saturate acc=%h sat=%b required=7fff/1", bus.acc_out, bus.sat_flag);
    end
    take_result();
    checks++;
    if (bus.sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear sat=%b required=0", bus.sat_flag);
    end
    send_pair(16'h8400, 16'h0400, 1'b0);
    send_pair(16'h0400, 16'h0400, 1'b1);
    wait_valid(1, e);
    checks++;
    if (bus.acc_out !== 16'h0000 || bus.sat_flag !== 1'b0 || bus.acc_valid !== 1'b1) begin
      failures++;
      $display("FAIL cancel_zero acc=%h sat=%b valid=%b required=0000/0/1", bus.acc_out, bus.sat_flag, bus.acc_valid);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    int   e;
    logic stable;
    send_pair(16'h0400, 16'h0800, 1'b1);
    wait_valid(1, e);
    bus.in_valid  = 1'b1;
    bus.in_neuron = 16'h0C00;
    bus.in_weight = 16'h0400;
    bus.in_last   = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.acc_valid !== 1'b1 || bus.acc_out !== 16'h0800 || bus.in_ready !== 1'b0 ||
          bus.mult_input_neuron !== 16'h0400) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL hold_stable stable=%b required=1 acc=%h", stable, bus.acc_out);
    end
    take_result();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mult_input_neuron !== 16'h0400) begin
      failures++;
      $display("FAIL hold_release rdy=%b neuron=%h required=1/0400", bus.in_ready, bus.mult_input_neuron);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mult_input_neuron !== 16'h0C00 || bus.mult_enable !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept neuron=%h en=%b required=0c00/1", bus.mult_input_neuron, bus.mult_enable);
    end
    wait_valid(1, e);
    checks++;
    if (bus.acc_out !== 16'h0C00) begin
      failures++;
      $display("FAIL b2b_result acc=%h required=0c00", bus.acc_out);
    end
    take_result();
  endtask

  task automatic test_reset_mid_run();
    int   e;
    logic seen;
    send_pair(16'h0600, 16'h0800, 1'b0);
    send_pair(16'h0400, 16'h0400, 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (bus.mult_enable !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_run_state en=%b busy=%b required=1/1", bus.mult_enable, bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mult_reset_n !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_reset_n mult_reset_n=%b rdy=%b required=0/0", bus.mult_reset_n, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.mult_enable, bus.acc_valid, bus.busy, bus.sat_flag} !== 4'b0 ||
        bus.acc_out !== 16'h0000 || bus.mult_input_neuron !== 16'h0000) begin
      failures++;
      $display("FAIL mid_run_cleared ctl=%b acc=%h neuron=%h required=0000/0000/0000",
               {bus.mult_enable, bus.acc_valid, bus.busy, bus.sat_flag}, bus.acc_out, bus.mult_input_neuron);
    end
    reset = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.acc_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_discard acc_valid_seen=%b required=0", seen);
    end
    send_pair(16'h0400, 16'h0400, 1'b1);
    wait_valid(1, e);
    checks++;
    if (bus.acc_out !== 16'h0400 || e !== 18) begin
      failures++;
      $display("FAIL after_reset acc=%h edges=%0d required=0400/18", bus.acc_out, e);
    end
    take_result();
  endtask

  task automatic test_zero_pair();
    int base;
    int e;
    base = en_cnt;
    send_pair(16'h0000, 16'h0800, 1'b1);
    wait_valid(1, e);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    checks++;
    if (e !== 2 || en_cnt - base !== 0) begin
      failures++;
      $display("FAIL zero_skip edges=%0d enables=%0d required=2/0", e, en_cnt - base);
    end
`else
    checks++;
    if (e !== 18 || en_cnt - base !== 16) begin
      failures++;
      $display("FAIL zero_full edges=%0d enables=%0d required=18/16", e, en_cnt - base);
    end
`endif
    checks++;
    if (bus.acc_out !== 16'h0000 || bus.acc_valid !== 1'b1) begin
      failures++;
      $display("FAIL zero_result acc=%h valid=%b required=0000/1", bus.acc_out, bus.acc_valid);
    end
    take_result();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_neuron = '0;
    bus.in_weight = '0;
    bus.in_last   = 1'b0;
    bus.acc_ready = 1'b0;
    test_reset();
    test_single();
    test_mixed_sign();
    test_saturate();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_pair();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
